// File: rtl/board_dbg_pkg.sv
// Shared definitions for the board debug controller.
//   - dbg_state_t : clock-enable FSM state encoding
//   - KEY_*       : bit positions of the push-buttons within key_n
//   - SEG_BLANK   : active-low pattern for an unlit digit
//   - hex_to_seg  : nibble -> active-low seven-segment pattern (g..a = [6:0])
package board_dbg_pkg;

  typedef enum logic [1:0] {
    STEP_IDLE  = 2'd0,
    STEP_PULSE = 2'd1,
    RUN        = 2'd2
  } dbg_state_t;

  localparam int KEY_STEP = 0;
  localparam int KEY_MODE = 1;
  localparam int KEY_HALT = 2;
  localparam int KEY_PAGE = 3;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low glyphs; b and d are the lowercase forms so they differ from 8 and 0.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Debouncer for one active-low push-button.
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   key_n      : raw asynchronous button level (0 = pressed)
//   pressed    : debounced level (1 = pressed)
//   press_evt  : one-cycle pulse on the released->pressed transition
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic pressed,
  output logic press_evt
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Everything resets to "released" so a key held through reset is
  // treated as a brand-new press once it has been stable long enough.
  logic             sync1_reg;
  logic             sync2_reg;
  logic             level_reg;   // debounced raw level, 1 = released
  logic [CNT_W-1:0] cnt_reg;

  logic differ;
  logic settle;

  assign differ = (sync2_reg != level_reg);
  // Last qualifying cycle: the debounced level flips on this clock edge.
  assign settle = differ && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      level_reg <= 1'b1;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= key_n;
      sync2_reg <= sync1_reg;
      if (!differ) begin
        cnt_reg <= '0;
      end else if (settle) begin
        level_reg <= sync2_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign pressed = ~level_reg;
  // Decoded from the settle condition so the consumer sees the event on the
  // same edge the debounced level changes.
  assign press_evt = settle & ~sync2_reg;

endmodule

// File: rtl/board_debug_ctrl.sv
// Board debug/display controller sitting between KEY buttons, HEX displays
// and the CPU core.
// Ports:
//   clk, rst    : system clock, synchronous active-high reset
//   key_n[3:0]  : raw active-low buttons: step, mode, halt, page
//   ch_data     : NUM_CH flattened DATA_W-bit debug channels
//   cpu_clk_en  : one-cycle CPU advance pulse (step or free-run)
//   cpu_hlt     : halt level (debounced halt key)
//   run_mode    : 1 while free-running
//   ch_sel      : channel currently on the display
//   hex_n       : NUM_DIGITS active-low seven-segment digits
module board_debug_ctrl
  import board_dbg_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int DATA_W          = 32,
  parameter int NUM_DIGITS      = 6,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int RUN_DIV         = 5000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [3:0]                 key_n,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data,
  output logic                       cpu_clk_en,
  output logic                       cpu_hlt,
  output logic                       run_mode,
  output logic [$clog2(NUM_CH)-1:0]  ch_sel,
  output logic [NUM_DIGITS*7-1:0]    hex_n
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  logic [3:0] key_pressed;
  logic [3:0] key_evt;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_key
      key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
        .clk       (clk),
        .rst       (rst),
        .key_n     (key_n[gi]),
        .pressed   (key_pressed[gi]),
        .press_evt (key_evt[gi])
      );
    end
  endgenerate

  // Only the halt key is used as a level; its press event is not needed.
  logic unused_keys;
  assign unused_keys = ^{key_pressed[KEY_STEP], key_pressed[KEY_MODE],
                         key_pressed[KEY_PAGE], key_evt[KEY_HALT]};

  logic step_evt, mode_evt, page_evt;
  assign step_evt = key_evt[KEY_STEP];
  assign mode_evt = key_evt[KEY_MODE];
  assign page_evt = key_evt[KEY_PAGE];

  // ---------------- clock-enable FSM ----------------
  dbg_state_t       state_reg, state_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic             pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= STEP_IDLE;
      div_reg   <= '0;
    end else begin
      state_reg <= state_next;
      div_reg   <= div_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    div_next   = div_reg;
    pulse      = 1'b0;
    case (state_reg)
      STEP_IDLE: begin
        // Mode takes priority over a coincident step.
        if (mode_evt) begin
          state_next = RUN;
          div_next   = '0;
        end else if (step_evt) begin
          state_next = STEP_PULSE;
        end
      end
      STEP_PULSE: begin
        pulse      = 1'b1;
        state_next = STEP_IDLE;
      end
      RUN: begin
        div_next = (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
        if (mode_evt) begin
          state_next = STEP_IDLE;
        end else begin
          pulse = (div_reg == DIV_LAST);
        end
      end
      default: state_next = STEP_IDLE;
    endcase
  end

  // Halt only masks the pulse; the FSM and divider keep going, so a step
  // taken while halted is swallowed.
  assign cpu_hlt    = key_pressed[KEY_HALT];
  assign cpu_clk_en = pulse & ~cpu_hlt;
  assign run_mode   = (state_reg == RUN);

  // ---------------- page select ----------------
  logic [CH_W-1:0] ch_sel_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_sel_reg <= '0;
    end else if (page_evt) begin
      ch_sel_reg <= (ch_sel_reg == CH_LAST) ? '0 : ch_sel_reg + 1'b1;
    end
  end

  assign ch_sel = ch_sel_reg;

  // ---------------- display ----------------
  logic [DATA_W-1:0]       sel_data;
  logic [NUM_DIGITS*7-1:0] hex_next;
  logic [NUM_DIGITS*7-1:0] hex_reg;

  assign sel_data = ch_data[int'(ch_sel_reg)*DATA_W +: DATA_W];

  generate
    for (gi = 0; gi < NUM_DIGITS - 1; gi++) begin : g_digit
      if (gi < DATA_W / 4) begin : g_nib
        assign hex_next[gi*7 +: 7] = hex_to_seg(sel_data[gi*4 +: 4]);
      end else begin : g_blank
        assign hex_next[gi*7 +: 7] = SEG_BLANK;
      end
    end
  endgenerate

  assign hex_next[(NUM_DIGITS-1)*7 +: 7] = hex_to_seg(4'(ch_sel_reg));

  always_ff @(posedge clk) begin
    if (rst) begin
      hex_reg <= {NUM_DIGITS*7{1'b1}};
    end else begin
      hex_reg <= hex_next;
    end
  end

  assign hex_n = hex_reg;

endmodule

// File: tb/tb_board_debug_ctrl.sv
// Directed bench for board_debug_ctrl with short debounce/divider settings.
module tb_board_debug_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   key_n;
  logic [127:0] ch_data;
  logic         cpu_clk_en;
  logic         cpu_hlt;
  logic         run_mode;
  logic [1:0]   ch_sel;
  logic [41:0]  hex_n;

  int errors    = 0;
  int checks    = 0;
  int cyc       = 0;
  int pulse_cnt = 0;
  int run_start = 0;
  int rel_cyc   = 0;
  int exp_cyc   = 0;
  int found     = -1;

  board_debug_ctrl #(
    .NUM_CH(4), .DATA_W(32), .NUM_DIGITS(6),
    .DEBOUNCE_CYCLES(4), .RUN_DIV(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_n      (key_n),
    .ch_data    (ch_data),
    .cpu_clk_en (cpu_clk_en),
    .cpu_hlt    (cpu_hlt),
    .run_mode   (run_mode),
    .ch_sel     (ch_sel),
    .hex_n      (hex_n)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cpu_clk_en === 1'b1) pulse_cnt++;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press_rel(input int k);
    key_n[k] = 1'b0;
    tick(7);
    key_n[k] = 1'b1;
    tick(8);
  endtask

  initial begin
    rst     = 1'b1;
    key_n   = 4'hF;
    ch_data = {32'hFEDCBA98, 32'h1234ABCD, 32'h0BADF00D, 32'h76543210};
    tick(3);
    rst = 1'b0;

    // Reset state
    chk("rst_clk_en", cpu_clk_en, 0);
    chk("rst_hlt", cpu_hlt, 0);
    chk("rst_run_mode", run_mode, 0);
    chk("rst_ch_sel", ch_sel, 0);
    tick(1);
    chk("rst_hex_ch0", hex_n, {7'h40, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40});

    // Step key with two short bounces, then stable low
    pulse_cnt = 0;
    key_n[0] = 1'b0; tick(2);
    key_n[0] = 1'b1; tick(1);
    key_n[0] = 1'b0; tick(2);
    key_n[0] = 1'b1; tick(1);
    key_n[0] = 1'b0; tick(5);
    chk("step_no_early_pulse", pulse_cnt, 0);
    tick(1);
    chk("step_pulse_at_6", cpu_clk_en, 1);
    tick(10);
    chk("step_single_pulse", pulse_cnt, 1);
    key_n[0] = 1'b1; tick(8);
    key_n[0] = 1'b0; tick(10);
    chk("step_second_pulse", pulse_cnt, 2);
    key_n[0] = 1'b1; tick(8);
    chk("step_release_no_pulse", pulse_cnt, 2);

    // RUN mode: one pulse per 8 cycles
    key_n[1] = 1'b0; tick(6);
    chk("run_enter", run_mode, 1);
    pulse_cnt = 0;
    tick(32);
    chk("run_4_pulses", pulse_cnt, 4);
    key_n[1] = 1'b1; tick(8);
    key_n[1] = 1'b0; tick(6);
    chk("run_exit", run_mode, 0);
    pulse_cnt = 0;
    tick(20);
    chk("step_idle_no_pulses", pulse_cnt, 0);
    key_n[1] = 1'b1; tick(8);

    // Halt during RUN
    key_n[1] = 1'b0; tick(6);
    run_start = cyc;
    chk("run_reenter", run_mode, 1);
    key_n[1] = 1'b1; tick(8);
    key_n[2] = 1'b0; tick(6);
    chk("halt_level", cpu_hlt, 1);
    pulse_cnt = 0;
    tick(24);
    chk("halt_no_pulses", pulse_cnt, 0);
    key_n[2] = 1'b1; tick(6);
    chk("halt_released", cpu_hlt, 0);
    rel_cyc = cyc;
    // Divider value after edge c is (c - run_start) mod 8; pulse at value 7.
    exp_cyc = rel_cyc + (7 - ((rel_cyc - run_start) % 8));
    found = -1;
    for (int i = 0; i < 10; i++) begin
      if (found < 0 && cpu_clk_en === 1'b1) found = cyc;
      tick(1);
    end
    chk("halt_resume_on_wrap", found, exp_cyc);
    key_n[1] = 1'b0; tick(6);
    chk("run_exit2", run_mode, 0);
    key_n[1] = 1'b1; tick(8);

    // Page cycling and display
    press_rel(3);
    press_rel(3);
    chk("page_ch_sel_2", ch_sel, 2);
    chk("page_hex_ch2", hex_n, {7'h24, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21});
    press_rel(3);
    press_rel(3);
    chk("page_wrap_0", ch_sel, 0);
    chk("page_wrap_digit5", hex_n[41:35], 7'h40);
    press_rel(3);
    press_rel(3);
    press_rel(3);
    chk("page_ch_sel_3", ch_sel, 3);
    chk("page_ch3_digit0", hex_n[6:0], 7'h00);
    ch_data[99:96] = 4'hF;
    chk("data_latency_old", hex_n[6:0], 7'h00);
    tick(1);
    chk("data_latency_new", hex_n[6:0], 7'h0E);
    chk("page_ch3_digit5", hex_n[41:35], 7'h30);

    // Simultaneous step + mode: mode wins, no pulse
    pulse_cnt = 0;
    key_n[0] = 1'b0;
    key_n[1] = 1'b0;
    tick(6);
    chk("both_run_mode", run_mode, 1);
    chk("both_no_pulse_now", cpu_clk_en, 0);
    tick(1);
    chk("both_no_pulse_after", pulse_cnt, 0);
    key_n[0] = 1'b1;
    key_n[1] = 1'b1;
    tick(8);

    // Reset while running on page 3
    rst = 1'b1;
    tick(1);
    chk("mid_rst_clk_en", cpu_clk_en, 0);
    chk("mid_rst_run_mode", run_mode, 0);
    chk("mid_rst_ch_sel", ch_sel, 0);
    rst = 1'b0;
    pulse_cnt = 0;
    tick(20);
    chk("mid_rst_no_pulses", pulse_cnt, 0);
    chk("mid_rst_hex_ch0", hex_n, {7'h40, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
